// File: rtl/dmem_write_buffer_port.sv
// dmem_write_buffer_port
//
// Pipeline-side initiator for the data memory. MEM-stage stores are queued
// in a small circular write buffer and drained to memory in the background;
// loads that hit a buffered store are forwarded combinationally, loads that
// miss stall the pipeline while a word read is issued over the memory
// req/ack handshake.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   Mem_Read     load command from the MEM stage
//   Mem_Write    store command from the MEM stage
//   Address      byte address (word index = Address[31:2])
//   Write_Data   store data
//   Read_Data    load result, valid when Mem_Read=1 and stall=0
//   stall        hold MEM stage and earlier stages this cycle
//   mem_req      registered memory request
//   mem_we       1=write, 0=read, stable while mem_req=1
//   mem_addr     word-aligned memory address, stable while mem_req=1
//   mem_wdata    write data, stable while mem_req=1
//   mem_ack      one-cycle completion pulse from memory
//   mem_rdata    read data, valid in the mem_ack cycle

module dmem_write_buffer_port #(
    parameter int WB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Mem_Read,
    input  logic        Mem_Write,
    input  logic [31:0] Address,
    input  logic [31:0] Write_Data,
    output logic [31:0] Read_Data,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int PW = $clog2(WB_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WR_BUSY,
        RD_BUSY,
        RD_DONE
    } state_t;

    state_t        state;
    logic [29:0]   wb_idx  [WB_DEPTH];
    logic [31:0]   wb_data [WB_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic [31:0]   rd_word;

    logic          hit;
    logic [31:0]   fwd_data;
    logic [PW-1:0] slot;
    logic          full;
    logic          load_miss;
    logic          enq;
    logic          deq;
    logic          addr_unused;

    // Byte offset bits never matter for word accesses.
    assign addr_unused = &{1'b0, Address[1:0]};

    // Walk the valid entries oldest to newest so the last match wins,
    // giving the newest buffered store to a forwarded load.
    always_comb begin
        hit      = 1'b0;
        fwd_data = 32'd0;
        slot     = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            slot = head + PW'(i);
            if (((PW+1)'(i) < count) && (wb_idx[slot] == Address[31:2])) begin
                hit      = 1'b1;
                fwd_data = wb_data[slot];
            end
        end
    end

    assign full      = (count == (PW+1)'(WB_DEPTH));
    assign load_miss = Mem_Read && !hit;
    // A store alongside a load is dropped; the load always wins.
    assign enq       = Mem_Write && !Mem_Read && !full;
    // The head entry stays visible to forwarding until the ack edge.
    assign deq       = (state == WR_BUSY) && mem_req && mem_ack;

    always_comb begin
        if (Mem_Read) begin
            stall = !hit && (state != RD_DONE);
        end else begin
            stall = Mem_Write && full;
        end
    end

    always_comb begin
        Read_Data = 32'd0;
        if (Mem_Read) begin
            if (hit) begin
                Read_Data = fwd_data;
            end else if (state == RD_DONE) begin
                Read_Data = rd_word;
            end
        end
    end

    // Buffer storage needs no reset: count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            wb_idx[tail]  <= Address[31:2];
            wb_data[tail] <= Write_Data;
        end
    end

    // Control FSM, buffer pointers and the registered memory interface.
    // A read following a drain enters RD_BUSY with mem_req low and raises it
    // one cycle later, which guarantees an idle cycle between requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            rd_word   <= 32'd0;
        end else begin
            if (enq) begin
                tail <= tail + PW'(1);
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (load_miss) begin
                        state    <= RD_BUSY;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {Address[31:2], 2'b00};
                    end else if (count != '0) begin
                        state     <= WR_BUSY;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {wb_idx[head], 2'b00};
                        mem_wdata <= wb_data[head];
                    end
                end
                WR_BUSY: begin
                    if (deq) begin
                        mem_req <= 1'b0;
                        state   <= load_miss ? RD_BUSY : IDLE;
                    end
                end
                RD_BUSY: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {Address[31:2], 2'b00};
                    end else if (mem_ack) begin
                        rd_word <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= RD_DONE;
                    end
                end
                RD_DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_write_buffer_port.sv
// Testbench for dmem_write_buffer_port: directed load/store sequences against
// a bench-side memory responder, a queue-based reference model checked every
// cycle, and hand-computed expectations for each scenario.

module tb_dmem_write_buffer_port;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        Mem_Read;
    logic        Mem_Write;
    logic [31:0] Address;
    logic [31:0] Write_Data;
    logic [31:0] Read_Data;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    dmem_write_buffer_port #(.WB_DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .Mem_Read   (Mem_Read),
        .Mem_Write  (Mem_Write),
        .Address    (Address),
        .Write_Data (Write_Data),
        .Read_Data  (Read_Data),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h",
                     name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        Mem_Read   = rd;
        Mem_Write  = wr;
        Address    = addr;
        Write_Data = data;
    endtask

    // ---------------- memory responder ----------------
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    op_t         ops[$];
    logic [31:0] mem_store [int];
    int          ack_delay = 0;
    bit          ack_hold  = 1'b0;
    bit          ack_once  = 1'b0;
    int          req_age   = 0;
    bit          acked_last = 1'b0;
    int          gap_err   = 0;

    function automatic int key(input logic [31:0] a);
        return int'(a >> 2);
    endfunction

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        forever begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 32'hFFFF_FFFF;
            if (acked_last && mem_req) gap_err++;
            acked_last = 1'b0;
            if (mem_req) begin
                if ((!ack_hold && req_age >= ack_delay) || ack_once) begin
                    mem_ack    = 1'b1;
                    ack_once   = 1'b0;
                    acked_last = 1'b1;
                    req_age    = 0;
                    if (mem_we) begin
                        mem_store[key(mem_addr)] = mem_wdata;
                        ops.push_back('{1'b1, mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = mem_store.exists(key(mem_addr)) ?
                                    mem_store[key(mem_addr)] : 32'd0;
                        ops.push_back('{1'b0, mem_addr, mem_rdata});
                    end
                end else begin
                    req_age++;
                end
            end else begin
                req_age = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [29:0] idx;
        logic [31:0] data;
    } ent_t;
    typedef enum {P_IDLE, P_WR, P_RD, P_DONE} phase_t;

    ent_t        q[$];
    phase_t      phase     = P_IDLE;
    bit          exp_req   = 1'b0;
    bit          exp_we    = 1'b0;
    logic [31:0] exp_addr  = 32'd0;
    logic [31:0] exp_wdata = 32'd0;
    logic [31:0] rd_word   = 32'd0;
    bit          seen_rst  = 1'b0;

    task automatic modelLookup(input logic [31:0] a, output bit h, output logic [31:0] d);
        h = 1'b0;
        d = 32'd0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].idx == a[31:2]) begin
                h = 1'b1;
                d = q[i].data;
                return;
            end
        end
    endtask

    initial begin
        bit          h;
        bit          miss;
        bit          full;
        bit          e_stall;
        bit          enq;
        bit          deq;
        logic [31:0] hd;
        forever begin
            @(negedge clk);
            #2;
            modelLookup(Address, h, hd);
            miss    = Mem_Read && !h;
            full    = (q.size() == D);
            e_stall = Mem_Read ? (!h && phase != P_DONE) : (Mem_Write && full);
            if (Mem_Read && Mem_Write)
                $display("[TB] note: Mem_Read and Mem_Write both high at %0t", $time);
            if (seen_rst) begin
                checkOutput("stall", {31'd0, stall}, {31'd0, e_stall});
                if (!Mem_Read)
                    checkOutput("Read_Data idle", Read_Data, 32'd0);
                else if (!e_stall)
                    checkOutput("Read_Data", Read_Data, h ? hd : rd_word);
                checkOutput("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
                if (exp_req) begin
                    checkOutput("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
                    checkOutput("mem_addr", mem_addr, exp_addr);
                    if (exp_we) checkOutput("mem_wdata", mem_wdata, exp_wdata);
                end
            end
            if (rst) begin
                q.delete();
                phase     = P_IDLE;
                exp_req   = 1'b0;
                exp_we    = 1'b0;
                exp_addr  = 32'd0;
                exp_wdata = 32'd0;
                rd_word   = 32'd0;
                seen_rst  = 1'b1;
            end else begin
                enq = Mem_Write && !Mem_Read && !full;
                deq = 1'b0;
                case (phase)
                    P_IDLE: begin
                        if (miss) begin
                            phase    = P_RD;
                            exp_req  = 1'b1;
                            exp_we   = 1'b0;
                            exp_addr = {Address[31:2], 2'b00};
                        end else if (q.size() > 0) begin
                            phase     = P_WR;
                            exp_req   = 1'b1;
                            exp_we    = 1'b1;
                            exp_addr  = {q[0].idx, 2'b00};
                            exp_wdata = q[0].data;
                        end
                    end
                    P_WR: begin
                        if (mem_ack) begin
                            deq     = 1'b1;
                            exp_req = 1'b0;
                            phase   = miss ? P_RD : P_IDLE;
                        end
                    end
                    P_RD: begin
                        if (!exp_req) begin
                            exp_req  = 1'b1;
                            exp_we   = 1'b0;
                            exp_addr = {Address[31:2], 2'b00};
                        end else if (mem_ack) begin
                            rd_word = mem_rdata;
                            exp_req = 1'b0;
                            phase   = P_DONE;
                        end
                    end
                    P_DONE: phase = P_IDLE;
                    default: phase = P_IDLE;
                endcase
                if (deq) void'(q.pop_front());
                if (enq) q.push_back('{Address[31:2], Write_Data});
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic waitNoStall(input string name, output int cycles);
        bit ok;
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!stall) begin
                ok = 1'b1;
                break;
            end
            cycles++;
            @(negedge clk);
        end
        checkOutput({name, " stall released"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic waitOps(input string name, input int n);
        for (int i = 0; i < 100 && ops.size() < n; i++) @(negedge clk);
        checkOutput({name, " memory ops"}, 32'(ops.size()), 32'(n));
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int stalls;
        int addr_bad;

        rst        = 1'b1;
        Mem_Read   = 1'b0;
        Mem_Write  = 1'b0;
        Address    = 32'd0;
        Write_Data = 32'd0;
        mem_store[key(32'h40)]  = 32'h1234_5678;
        mem_store[key(32'h20)]  = 32'h5555_AAAA;
        mem_store[key(32'h400)] = 32'h0BAD_F00D;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset stall", {31'd0, stall}, 32'd0);
        checkOutput("reset Read_Data", Read_Data, 32'd0);
        checkOutput("reset mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("reset mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("reset mem_addr", mem_addr, 32'd0);
        checkOutput("reset mem_wdata", mem_wdata, 32'd0);

        // Store then immediate load of the same word: forwarded, no read.
        ack_delay = 0;
        ops.delete();
        applyStimulus(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF);
        #1 checkOutput("store stall", {31'd0, stall}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h100, 32'd0);
        #1;
        checkOutput("fwd stall", {31'd0, stall}, 32'd0);
        checkOutput("fwd data", Read_Data, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        waitOps("fwd", 1);
        checkOutput("fwd drain is write", {31'd0, ops[0].we}, 32'd1);
        checkOutput("fwd drain addr", ops[0].addr, 32'h100);
        checkOutput("fwd drain data", ops[0].data, 32'hDEAD_BEEF);
        repeat (3) @(negedge clk);

        // Load miss on empty buffer, ack in the third request cycle.
        ack_delay = 2;
        ops.delete();
        addr_bad  = 0;
        stalls    = 0;
        applyStimulus(1'b1, 1'b0, 32'h40, 32'd0);
        for (int i = 0; i < 50; i++) begin
            #1;
            if (!stall) break;
            stalls++;
            if (mem_req && (mem_addr != 32'h40 || mem_we != 1'b0)) addr_bad++;
            @(negedge clk);
        end
        checkOutput("miss stall cycles", 32'(stalls), 32'd4);
        checkOutput("miss data", Read_Data, 32'h1234_5678);
        checkOutput("miss addr held", 32'(addr_bad), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);

        // Two stores to one word, load before drain sees the newest.
        ack_delay = 1;
        ops.delete();
        applyStimulus(1'b0, 1'b1, 32'h8, 32'd1);
        applyStimulus(1'b0, 1'b1, 32'h8, 32'd2);
        applyStimulus(1'b1, 1'b0, 32'h8, 32'd0);
        #1;
        checkOutput("newest fwd stall", {31'd0, stall}, 32'd0);
        checkOutput("newest fwd data", Read_Data, 32'd2);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        waitOps("ordered", 2);
        checkOutput("first write data", ops[0].data, 32'd1);
        checkOutput("second write data", ops[1].data, 32'd2);
        checkOutput("second write addr", ops[1].addr, 32'h8);
        repeat (3) @(negedge clk);

        // Fill the buffer with ack held, then release one ack.
        ack_hold = 1'b1;
        ops.delete();
        for (int i = 0; i < D; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
            #1 checkOutput("fill stall", {31'd0, stall}, 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 32'h210, 32'hA4);
        #1 checkOutput("full stall", {31'd0, stall}, 32'd1);
        ack_once = 1'b1;
        @(negedge clk);
        #1 checkOutput("full stall in ack cycle", {31'd0, stall}, 32'd1);
        @(negedge clk);
        #1 checkOutput("enqueue after dequeue", {31'd0, stall}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h214, 32'hA5);
        #1 checkOutput("full again", {31'd0, stall}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        ack_hold  = 1'b0;
        ack_delay = 0;
        waitOps("wrap", 5);
        for (int i = 0; i < 5 && i < ops.size(); i++) begin
            checkOutput("wrap order addr", ops[i].addr, 32'h200 + 32'(4 * i));
            checkOutput("wrap order data", ops[i].data, 32'hA0 + 32'(i));
        end
        repeat (3) @(negedge clk);

        // Load miss arriving while a drain is outstanding.
        ack_delay = 2;
        ops.delete();
        applyStimulus(1'b0, 1'b1, 32'h10, 32'hAA);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        #1 checkOutput("drain in progress", {30'd0, mem_req, mem_we}, 32'd3);
        applyStimulus(1'b1, 1'b0, 32'h20, 32'd0);
        waitNoStall("miss behind drain", stalls);
        checkOutput("miss behind drain data", Read_Data, 32'h5555_AAAA);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        waitOps("drain then read", 2);
        checkOutput("drain first", {31'd0, ops[0].we}, 32'd1);
        checkOutput("drain addr", ops[0].addr, 32'h10);
        checkOutput("read second", {31'd0, ops[1].we}, 32'd0);
        checkOutput("read addr", ops[1].addr, 32'h20);
        repeat (3) @(negedge clk);

        // Reset during RD_BUSY with a coincident ack.
        ack_hold = 1'b1;
        ops.delete();
        applyStimulus(1'b0, 1'b1, 32'h400, 32'h1111_1111);
        applyStimulus(1'b1, 1'b0, 32'h300, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h300, 32'd0);
        #1 checkOutput("read outstanding", {30'd0, mem_req, mem_we}, 32'd2);
        ack_once = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        Mem_Read  = 1'b0;
        Mem_Write = 1'b0;
        #1;
        checkOutput("post-reset mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("post-reset stall", {31'd0, stall}, 32'd0);
        checkOutput("post-reset Read_Data", Read_Data, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h400, 32'd0);
        #1 checkOutput("store discarded", {31'd0, stall}, 32'd1);
        ack_hold  = 1'b0;
        ack_delay = 0;
        waitNoStall("post-reset load", stalls);
        checkOutput("post-reset load data", Read_Data, 32'h0BAD_F00D);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);

        checkOutput("idle gap between requests", 32'(gap_err), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
